// File: rtl/dac_frame_sequencer_pkg.sv
// Shared definitions for the DAC frame sequencer: FSM state encoding,
// DAC write-word field layout and the word-format helper.
package dac_pkg;

  // Sequencer FSM states, exposed on the debug port as well.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    LOAD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // 16-bit DAC write word layout.
  localparam int WORD_W    = 16;
  localparam int WRITE_BIT = 15;
  localparam int ADDR_MSB  = 14;
  localparam int ADDR_LSB  = 12;
  localparam int CODE_W    = 12;

  // Build one DAC write word: write command bit low, 3-bit channel address,
  // 12-bit code.
  function automatic logic [WORD_W-1:0] fmt_word(input logic [2:0]        addr,
                                                 input logic [CODE_W-1:0] code);
    logic [WORD_W-1:0] w;
    w                    = '0;
    w[WRITE_BIT]         = 1'b0;
    w[ADDR_MSB:ADDR_LSB] = addr;
    w[CODE_W-1:0]        = code;
    return w;
  endfunction

endpackage

// File: rtl/dac_frame_sequencer_if.sv
// Word hand-off between the frame sequencer and the serial DAC transmitter.
//
// Handshake: the sequencer holds ser_data stable from at least one cycle
// before ser_start until the transfer completes. ser_start is a single-cycle
// pulse. ser_done is a level that idles high; the transmitter lowers it while
// shifting and a word counts as delivered only on its low-to-high transition.
interface dac_frame_sequencer_if;
  import dac_pkg::*;

  logic [WORD_W-1:0] ser_data;
  logic              ser_start;
  logic              ser_done;

  modport master (output ser_data, output ser_start, input  ser_done);
  modport slave  (input  ser_data, input  ser_start, output ser_done);

endinterface

// File: rtl/dac_frame_sequencer.sv
// DAC frame sequencer: on a trigger, snapshots the channel enables and codes,
// sends one formatted write word per enabled channel (ascending order) to the
// serial transmitter, then strobes the active-low LDAC pin so every channel
// updates at once. One further trigger can be queued while a frame is running;
// any beyond that is dropped and reported on overrun.
module dac_frame_sequencer
  import dac_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trigger,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*CODE_W-1:0] ch_data,
  input  logic [15:0]              ldac_width,
  dac_frame_sequencer_if.master    ser,
  output logic                     LDAC,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun,
  output state_t                   dbg_state
);

  state_t            state;
  state_t            state_nxt;

  logic [IDX_W-1:0]  idx;
  logic [NUM_CH-1:0] en_snap;
  logic [CODE_W-1:0] code_snap [NUM_CH];
  logic              pending;
  logic              sent_any;
  logic              done_q;
  logic [15:0]       ldac_cnt;

  // Per-cycle control strobes decoded by the FSM.
  logic              accept;
  logic              idx_inc;
  logic              load_word;
  logic              ldac_load;

  logic              cur_en;
  logic [CODE_W-1:0] cur_code;
  logic              idx_end;
  logic              done_rise;

  // ser_done idles high between words, so only its rising edge marks completion.
  assign done_rise = ser.ser_done & ~done_q;
  assign idx_end   = (idx == IDX_W'(NUM_CH));
  assign dbg_state = state;

  // Select the snapshotted enable and code for the channel under the index.
  always_comb begin
    cur_en   = 1'b0;
    cur_code = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_en   = en_snap[i];
        cur_code = code_snap[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    idx_inc   = 1'b0;
    load_word = 1'b0;
    ldac_load = 1'b0;
    case (state)
      IDLE: begin
        if (trigger || pending) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (idx_end) begin
          // An all-disabled frame skips LDAC: nothing new was written.
          if (sent_any) begin
            ldac_load = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = DONE;
          end
        end else if (!cur_en) begin
          idx_inc = 1'b1;
        end else begin
          load_word = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done_rise) begin
          idx_inc   = 1'b1;
          state_nxt = SCAN;
        end
      end
      LOAD: begin
        if (ldac_cnt <= 16'd1) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame snapshot, channel index, queued trigger and LDAC low-time counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      en_snap  <= '0;
      pending  <= 1'b0;
      sent_any <= 1'b0;
      done_q   <= 1'b0;
      ldac_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        code_snap[i] <= '0;
      end
    end else begin
      done_q <= ser.ser_done;

      if (accept) begin
        idx      <= '0;
        sent_any <= 1'b0;
        en_snap  <= ch_en;
        for (int i = 0; i < NUM_CH; i++) begin
          code_snap[i] <= ch_data[i*CODE_W +: CODE_W];
        end
      end else if (idx_inc) begin
        idx <= idx + 1'b1;
      end

      if (load_word) begin
        sent_any <= 1'b1;
      end

      // A zero width still gives one LDAC-low cycle.
      if (ldac_load) begin
        ldac_cnt <= (ldac_width == 16'd0) ? 16'd1 : ldac_width;
      end else if (state == LOAD) begin
        ldac_cnt <= ldac_cnt - 16'd1;
      end

      // A trigger seen in IDLE is merged into the frame accepted this cycle;
      // otherwise it is queued once.
      if (accept) begin
        pending <= 1'b0;
      end else if (trigger && !pending) begin
        pending <= 1'b1;
      end
    end
  end

  // Registered outputs. ser_start rises one cycle after START so the word has
  // been stable a full cycle before the transmitter sees the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ser.ser_data  <= '0;
      ser.ser_start <= 1'b0;
      LDAC          <= 1'b1;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (load_word) begin
        ser.ser_data <= fmt_word(3'(idx), cur_code);
      end
      ser.ser_start <= (state == START);
      LDAC          <= (state_nxt != LOAD);
      busy          <= (state_nxt != IDLE);
      frame_done    <= (state_nxt == DONE);
      overrun       <= trigger && !accept && pending;
    end
  end

endmodule
